// File: rtl/lcd_ctrl_pkg.sv
// lcd_ctrl_pkg: shared types and default timing for the HD44780 write controller.
//   lcd_state_t  - controller FSM states
//   DEF_*        - default phase lengths in clk cycles
//   DLY_W        - width of the phase delay counter
//   is_poll_st / is_write_st - phase classification helpers
package lcd_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POLL_SETUP,
    POLL_EHIGH,
    POLL_HOLD,
    POLL_GAP,
    WR_SETUP,
    WR_EHIGH,
    WR_HOLD
  } lcd_state_t;

  localparam int unsigned DEF_SETUP_CYC    = 2;
  localparam int unsigned DEF_E_HIGH_CYC   = 12;
  localparam int unsigned DEF_HOLD_CYC     = 2;
  localparam int unsigned DEF_POLL_GAP_CYC = 4;
  localparam int unsigned DEF_BUSY_TIMEOUT = 100000;

  localparam int DLY_W = 16;

  // Busy-flag read phase, including the E-low gap between reads.
  function automatic logic is_poll_st(input lcd_state_t s);
    return (s == POLL_SETUP) || (s == POLL_EHIGH) ||
           (s == POLL_HOLD)  || (s == POLL_GAP);
  endfunction

  function automatic logic is_write_st(input lcd_state_t s);
    return (s == WR_SETUP) || (s == WR_EHIGH) || (s == WR_HOLD);
  endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// lcd_delay_cnt: loadable down-counter timing each controller phase.
//   clk, RST  - clock, asynchronous active-high reset
//   load      - load load_val this edge (load wins over counting)
//   load_val  - phase length minus one
//   done      - counter is at zero: current cycle is the last of the phase
module lcd_delay_cnt
  import lcd_ctrl_pkg::*;
#(
  parameter int W = DLY_W
) (
  input  logic         clk,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780 byte writer. Each accepted request polls the busy flag
// (read instruction register, DB7) until clear or until the poll budget is
// spent, then performs one write of the captured byte.
//   clk, RST           - clock, asynchronous active-high reset
//   req_valid/req_ready- request handshake; req_rs/req_data captured on accept
//   busy               - transaction in progress (complement of req_ready)
//   timeout_err/err_clr- sticky busy-flag timeout and its clear
//   lcd_e/rw/rs        - HD44780 control pins
//   lcd_db_o/oe/i      - data bus drive value, drive enable, read value
//   dbg_state          - current FSM state
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE; req_valid is
// ignored in every other state and the requester may hold it indefinitely.
module lcd_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int unsigned SETUP_CYC    = DEF_SETUP_CYC,
  parameter int unsigned E_HIGH_CYC   = DEF_E_HIGH_CYC,
  parameter int unsigned HOLD_CYC     = DEF_HOLD_CYC,
  parameter int unsigned POLL_GAP_CYC = DEF_POLL_GAP_CYC,
  parameter int unsigned BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       busy,
  output logic       timeout_err,
  input  logic       err_clr,
  output logic       lcd_e,
  output logic       lcd_rw,
  output logic       lcd_rs,
  output logic [7:0] lcd_db_o,
  output logic       lcd_db_oe,
  input  logic [7:0] lcd_db_i,
  output lcd_state_t dbg_state
);

  lcd_state_t       state, state_nxt;
  logic             dly_load, dly_done;
  logic [DLY_W-1:0] dly_val;
  logic             cap_rs;
  logic [7:0]       cap_data;
  logic             busy_flag;
  logic [31:0]      to_cnt;
  logic             poll_ph, accept, to_expired, to_hit;
  logic             db_low_unused;

  // Only DB7 (busy flag) is read back.
  assign db_low_unused = ^lcd_db_i[6:0];

  assign dbg_state = state;
  assign accept    = (state == IDLE) && req_valid;
  assign poll_ph   = is_poll_st(state);
  // Counting the current poll cycle, the budget is used up.
  assign to_expired = (to_cnt >= 32'(BUSY_TIMEOUT - 1));
  assign to_hit     = poll_ph && (to_cnt == 32'(BUSY_TIMEOUT - 1));

  lcd_delay_cnt #(.W(DLY_W)) u_dly (
    .clk      (clk),
    .RST      (RST),
    .load     (dly_load),
    .load_val (dly_val),
    .done     (dly_done)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (req_valid) state_nxt = POLL_SETUP;
      POLL_SETUP: if (dly_done)  state_nxt = POLL_EHIGH;
      POLL_EHIGH: if (dly_done)  state_nxt = POLL_HOLD;
      // The E pulse in flight always completes; the timeout only redirects
      // the decision taken at the end of its hold.
      POLL_HOLD:  if (dly_done)  state_nxt = (busy_flag && !to_expired) ? POLL_GAP : WR_SETUP;
      POLL_GAP:   if (dly_done)  state_nxt = POLL_SETUP;
      WR_SETUP:   if (dly_done)  state_nxt = WR_EHIGH;
      WR_EHIGH:   if (dly_done)  state_nxt = WR_HOLD;
      WR_HOLD:    if (dly_done)  state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase

    // Every state change reloads the counter with the new phase length.
    dly_load = (state_nxt != state);
    dly_val  = '0;
    case (state_nxt)
      POLL_SETUP, WR_SETUP: dly_val = DLY_W'(SETUP_CYC - 1);
      POLL_EHIGH, WR_EHIGH: dly_val = DLY_W'(E_HIGH_CYC - 1);
      POLL_HOLD,  WR_HOLD:  dly_val = DLY_W'(HOLD_CYC - 1);
      POLL_GAP:             dly_val = DLY_W'(POLL_GAP_CYC - 1);
      default:              dly_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      cap_rs      <= 1'b0;
      cap_data    <= 8'h00;
      busy_flag   <= 1'b0;
      to_cnt      <= '0;
      timeout_err <= 1'b0;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      lcd_e       <= 1'b0;
      lcd_rw      <= 1'b0;
      lcd_rs      <= 1'b0;
      lcd_db_o    <= 8'h00;
      lcd_db_oe   <= 1'b0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        cap_rs   <= req_rs;
        cap_data <= req_data;
      end

      if ((state == POLL_EHIGH) && dly_done) begin
        busy_flag <= lcd_db_i[7];
      end

      // Saturates at the limit so the set event fires exactly once.
      if (accept) begin
        to_cnt <= '0;
      end else if (poll_ph && (to_cnt != 32'(BUSY_TIMEOUT))) begin
        to_cnt <= to_cnt + 32'd1;
      end

      if (to_hit) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end

      // Pins are registered from the next state so they change together
      // with the state register and never glitch.
      req_ready <= (state_nxt == IDLE);
      busy      <= (state_nxt != IDLE);
      lcd_e     <= (state_nxt == POLL_EHIGH) || (state_nxt == WR_EHIGH);
      lcd_rw    <= is_poll_st(state_nxt);
      lcd_rs    <= is_write_st(state_nxt) ? cap_rs : 1'b0;
      lcd_db_oe <= is_write_st(state_nxt);
      if (is_write_st(state_nxt)) begin
        lcd_db_o <= cap_data;
      end
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: self-checking bench for lcd_ctrl. A waveform model expands
// each accepted request into its expected per-cycle pin schedule, and one
// negedge process compares the DUT pins against it every cycle.
module tb_lcd_ctrl;

  localparam int SETUP = 2;
  localparam int EH    = 12;
  localparam int HOLD  = 2;
  localparam int GAP   = 4;
  localparam int T     = 200;
  localparam int EW    = 15;

  typedef struct packed {
    logic       e;
    logic       rw;
    logic       rs;
    logic       oe;
    logic [7:0] db;
    logic       tset;  // this cycle brings the poll count to the limit
    logic       smp;   // DUT samples DB7 at the end of this cycle
    logic       bsy;   // DB7 value to present on a sampling cycle
  } ent_t;

  logic       clk, RST;
  logic       req_valid, req_rs, req_ready, busy, timeout_err, err_clr;
  logic [7:0] req_data;
  logic       lcd_e, lcd_rw, lcd_rs, lcd_db_oe;
  logic [7:0] lcd_db_o, lcd_db_i;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  lcd_ctrl #(
    .SETUP_CYC    (SETUP),
    .E_HIGH_CYC   (EH),
    .HOLD_CYC     (HOLD),
    .POLL_GAP_CYC (GAP),
    .BUSY_TIMEOUT (T)
  ) dut (
    .clk         (clk),
    .RST         (RST),
    .req_valid   (req_valid),
    .req_rs      (req_rs),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr),
    .lcd_e       (lcd_e),
    .lcd_rw      (lcd_rw),
    .lcd_rs      (lcd_rs),
    .lcd_db_o    (lcd_db_o),
    .lcd_db_oe   (lcd_db_oe),
    .lcd_db_i    (lcd_db_i),
    .dbg_state   (dbg_state)
  );

  // ---------------- model ----------------
  logic [EW-1:0] exp_q[$];
  logic          m_terr;
  logic [7:0]    m_last_db;
  int            busy_n;     // polls of the next transaction that read busy
  ent_t          m_pop;

  function automatic ent_t front_ent();
    if (exp_q.size() == 0) return '0;
    return ent_t'(exp_q[0]);
  endfunction

  function automatic void push_ent(input logic e, input logic rw, input logic rs,
                                   input logic oe, input logic [7:0] db,
                                   input logic tset, input logic smp, input logic bsy);
    ent_t n;
    n.e = e; n.rw = rw; n.rs = rs; n.oe = oe; n.db = db;
    n.tset = tset; n.smp = smp; n.bsy = bsy;
    exp_q.push_back(n);
  endfunction

  // Expected pin schedule of one transaction, one entry per clk cycle.
  function automatic void build_txn(input logic rs, input logic [7:0] data, input int nb);
    int   pc;
    int   k;
    logic b;
    logic more;
    pc = 0; k = 0; more = 1'b1;
    while (more) begin
      b = (k < nb);
      for (int i = 0; i < SETUP; i++) begin pc++; push_ent(0, 1, 0, 0, m_last_db, pc == T, 0, 0); end
      for (int i = 0; i < EH; i++)    begin pc++; push_ent(1, 1, 0, 0, m_last_db, pc == T, i == EH - 1, b); end
      for (int i = 0; i < HOLD; i++)  begin pc++; push_ent(0, 1, 0, 0, m_last_db, pc == T, 0, 0); end
      k++;
      if (b && pc < T) begin
        for (int i = 0; i < GAP; i++) begin pc++; push_ent(0, 1, 0, 0, m_last_db, pc == T, 0, 0); end
      end else begin
        more = 1'b0;
      end
    end
    for (int i = 0; i < SETUP; i++) push_ent(0, 0, rs, 1, data, 0, 0, 0);
    for (int i = 0; i < EH; i++)    push_ent(1, 0, rs, 1, data, 0, 0, 0);
    for (int i = 0; i < HOLD; i++)  push_ent(0, 0, rs, 1, data, 0, 0, 0);
    m_last_db = data;
  endfunction

  always @(posedge clk or posedge RST) begin
    if (RST) begin
      exp_q.delete();
      m_terr    = 1'b0;
      m_last_db = 8'h00;
    end else begin
      m_pop = '0;
      if (exp_q.size() > 0) m_pop = ent_t'(exp_q.pop_front());
      else if (req_valid)   build_txn(req_rs, req_data, busy_n);
      if (m_pop.tset)   m_terr = 1'b1;
      else if (err_clr) m_terr = 1'b0;
    end
  end

  // Bus read value: DB7 follows the schedule on sampling cycles, random elsewhere.
  always @(negedge clk) begin
    logic [7:0] r;
    ent_t f;
    r = 8'($urandom);
    f = front_ent();
    if (exp_q.size() > 0 && f.smp) r[7] = f.bsy;
    lcd_db_i = r;
  end

  // ---------------- scoreboard / protocol compare ----------------
  logic [8:0]    wr_log[$];   // {rs, data} at each write E rise
  logic          p_e, p_rw, p_rs, p_oe;
  ent_t          cf;
  logic [EW-1:0] ev, gv;

  always @(negedge clk) begin
    if (RST) begin
      p_e = 1'b0; p_rw = 1'b0; p_rs = 1'b0; p_oe = 1'b0;
    end else begin
      cf = front_ent();
      if (exp_q.size() > 0) ev = {1'b0, 1'b1, m_terr, cf.e, cf.rw, cf.rs, cf.oe, cf.db};
      else                  ev = {1'b1, 1'b0, m_terr, 4'b0000, m_last_db};
      gv = {req_ready, busy, timeout_err, lcd_e, lcd_rw, lcd_rs, lcd_db_oe, lcd_db_o};
      checks++;
      if (gv !== ev) begin
        errors++;
        $display("FAIL model_cmp t=%0t got=%h exp=%h (ready,busy,terr,e,rw,rs,oe,db)", $time, gv, ev);
      end
      checks++;
      if (lcd_db_oe && lcd_rw) begin
        errors++;
        $display("FAIL proto_oe_rw t=%0t got oe=1 rw=1 required not both", $time);
      end
      if (p_e || lcd_e) begin
        checks++;
        if ({lcd_rs, lcd_rw, lcd_db_oe} !== {p_rs, p_rw, p_oe}) begin
          errors++;
          $display("FAIL proto_stable t=%0t got rs/rw/oe=%b required %b around E high",
                   $time, {lcd_rs, lcd_rw, lcd_db_oe}, {p_rs, p_rw, p_oe});
        end
      end
      if (lcd_e && !p_e && !lcd_rw) wr_log.push_back({lcd_rs, lcd_db_o});
      p_e = lcd_e; p_rw = lcd_rw; p_rs = lcd_rs; p_oe = lcd_db_oe;
    end
  end

  // ---------------- driver tasks ----------------
  logic clr_rand;

  task automatic tick();
    @(negedge clk);
    err_clr = clr_rand ? ($urandom_range(0, 7) == 0) : 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [8:0] last_wr();
    if (wr_log.size() == 0) return 9'h1FF;
    return wr_log[wr_log.size() - 1];
  endfunction

  task automatic wait_ready(input int budget, output int waited);
    waited = 0;
    while (!req_ready && waited < budget) begin tick(); waited++; end
    if (!req_ready) begin
      errors++; checks++;
      $display("FAIL wait_ready got ready=0 after %0d cycles required 1", waited);
    end
  endtask

  task automatic run_txn(input logic rs, input logic [7:0] d, input int nb,
                         output int lo, output int pulses, output int ehigh);
    int   w;
    logic pe;
    busy_n = nb; req_rs = rs; req_data = d; req_valid = 1'b1;
    wait_ready(1000, w);
    tick();
    req_valid = 1'b0;
    lo = 0; pulses = 0; ehigh = 0; pe = 1'b0;
    while (!req_ready && lo < 2000) begin
      lo++;
      if (lcd_e) ehigh++;
      if (lcd_e && !pe) pulses++;
      pe = lcd_e;
      tick();
    end
    if (!req_ready) begin
      errors++; checks++;
      $display("FAIL txn_done got ready=0 after %0d cycles required 1", lo);
    end
  endtask

  // ---------------- stimulus ----------------
  int         lo, pulses, eh, w, n0;
  logic [7:0] b2b [3];

  initial begin
    RST = 1'b0; req_valid = 1'b0; req_rs = 1'b0; req_data = 8'h00;
    err_clr = 1'b0; busy_n = 0; clr_rand = 1'b0;
    b2b[0] = 8'h38; b2b[1] = 8'h0C; b2b[2] = 8'h06;
    #1 RST = 1'b1;
    repeat (3) @(negedge clk);
    #2 RST = 1'b0;
    tick();

    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pins", {lcd_e, lcd_rw, lcd_rs, lcd_db_oe}, 0);
    chk("rst_db_o", lcd_db_o, 8'h00);
    chk("rst_terr", timeout_err, 0);

    // Not busy: one poll pulse, one write pulse.
    run_txn(1'b1, 8'h48, 0, lo, pulses, eh);
    chk("t1_ready_low", lo, 32);
    chk("t1_pulses", pulses, 2);
    chk("t1_e_high", eh, 24);
    chk("t1_write", last_wr(), {1'b1, 8'h48});

    // Busy on the first two polls.
    run_txn(1'b0, 8'h01, 2, lo, pulses, eh);
    chk("t2_ready_low", lo, 3 * 16 + 2 * 4 + 16);
    chk("t2_pulses", pulses, 4);
    chk("t2_write", last_wr(), {1'b0, 8'h01});
    chk("t2_terr", timeout_err, 0);

    // Busy forever: forced write after the poll budget.
    run_txn(1'b0, 8'h01, 1000, lo, pulses, eh);
    chk("t3_ready_low", lo, 232);
    chk("t3_pulses", pulses, 12);
    chk("t3_write", last_wr(), {1'b0, 8'h01});
    chk("t3_terr_set", timeout_err, 1);
    err_clr = 1'b1;
    tick();
    chk("t3_terr_clr", timeout_err, 0);

    // Back-to-back with req_valid held high.
    wr_log.delete();
    busy_n = 0; req_rs = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_data = b2b[i];
      wait_ready(1000, w);
      if (i > 0) chk("b2b_spacing", w, 32);
      tick();
    end
    req_valid = 1'b0;
    wait_ready(1000, w);
    chk("b2b_count", wr_log.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < wr_log.size()) chk("b2b_order", wr_log[i], {1'b0, b2b[i]});
    end

    // Randomized traffic with random error clears.
    clr_rand = 1'b1;
    for (int n = 0; n < 25; n++) begin
      run_txn(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 12), lo, pulses, eh);
      repeat ($urandom_range(0, 3)) tick();
    end
    clr_rand = 1'b0;
    tick();

    // Reset during the write E pulse.
    busy_n = 0; req_rs = 1'b1; req_data = 8'hA5; req_valid = 1'b1;
    wait_ready(1000, w);
    tick();
    req_valid = 1'b0;
    w = 0;
    while (!(front_ent().e && !front_ent().rw && exp_q.size() > 0) && w < 200) begin tick(); w++; end
    chk("rw_reached_write", w < 200, 1);
    tick();
    #2 RST = 1'b1;
    #1;
    chk("rw_e_drop", lcd_e, 0);
    chk("rw_oe_drop", lcd_db_oe, 0);
    @(negedge clk);
    #2 RST = 1'b0;
    tick();
    chk("rw_ready", req_ready, 1);
    n0 = wr_log.size();
    repeat (40) tick();
    chk("rw_no_retry", wr_log.size(), n0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog got no completion required finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2, RS/RW-to-E-rise setup in clk cycles.
REQ-002 SHALL have parameter E_HIGH_CYC, default 12, E high pulse width in clk cycles.
REQ-003 SHALL have parameter HOLD_CYC, default 2, E-fall-to-bus/RS/RW change hold in clk cycles.
REQ-004 SHALL have parameter POLL_GAP_CYC, default 4, E-low idle between busy polls.
REQ-005 SHALL have parameter BUSY_TIMEOUT, default 100000, maximum poll cycles before forced write (2 ms at 50 MHz).
REQ-006 SHALL have ports, one clock and one reset, asynchronous active-high:
 clk  in  1  system clock, 50 MHz nominal
 RST  in  1  asynchronous active-high reset
 req_valid  in  1  byte request present
 req_rs  in  1  0 = instruction, 1 = data
 req_data  in  8  byte to write
 req_ready  out  1  controller accepts request
 busy  out  1  transaction in progress (= ~req_ready)
 timeout_err  out  1  sticky busy-flag timeout
 err_clr  in  1  clears timeout_err
 lcd_e  out  1  HD44780 enable
 lcd_rw  out  1  1 = read, 0 = write
 lcd_rs  out  1  register select
 lcd_db_o  out  8  data bus drive value
 lcd_db_oe  out  1  1 = drive data bus
 lcd_db_i  in  8  data bus read value (DB7 = busy flag)

Function
REQ-007 SHALL accept a request on a rising clk edge where req_valid && req_ready; req_rs/req_data captured into internal registers on that edge.
REQ-008 SHALL assert req_ready only in IDLE; req_valid ignored elsewhere.
REQ-009 SHALL implement states IDLE, POLL_SETUP, POLL_EHIGH, POLL_HOLD, POLL_GAP, WR_SETUP, WR_EHIGH, WR_HOLD.
REQ-010 IDLE -> POLL_SETUP on accept; each timed state lasts exactly its parameter in cycles.
REQ-011 Poll phase: lcd_rs=0, lcd_rw=1, lcd_db_oe=0; lcd_e=1 only in POLL_EHIGH.
REQ-012 SHALL sample lcd_db_i[7] on the last POLL_EHIGH cycle; 0 -> POLL_HOLD then WR_SETUP; 1 -> POLL_HOLD then POLL_GAP then POLL_SETUP.
REQ-013 Write phase: lcd_rs=captured rs, lcd_rw=0, lcd_db_oe=1, lcd_db_o=captured data across WR_SETUP/WR_EHIGH/WR_HOLD; lcd_e=1 only in WR_EHIGH.
REQ-014 WR_HOLD -> IDLE; req_ready high the cycle after the last WR_HOLD cycle.
REQ-015 Not-busy latency: req_ready low exactly 2*(SETUP_CYC+E_HIGH_CYC+HOLD_CYC) cycles (32 at defaults).
REQ-016 lcd_rs, lcd_rw, lcd_db_oe SHALL change only while lcd_e=0; lcd_db_oe never 1 while lcd_rw=1.
REQ-017 Timeout counter cleared on accept, increments each poll-phase cycle; reaching BUSY_TIMEOUT sets timeout_err and forces POLL_HOLD -> WR_SETUP (current E pulse completes first).
REQ-018 timeout_err sticky; err_clr clears it next edge; simultaneous set and err_clr -> set wins.
REQ-019 Outside poll/write phases: lcd_e=0, lcd_rw=0, lcd_rs=0, lcd_db_oe=0, lcd_db_o holds last value.
REQ-020 All outputs registered; no combinational path from lcd_db_i to any output.

Reset
REQ-021 RST SHALL asynchronously force state IDLE, lcd_e=0, lcd_rw=0, lcd_rs=0, lcd_db_o=8'h00, lcd_db_oe=0, timeout_err=0, counters 0, req_ready=1 after release.
REQ-022 RST mid-transaction SHALL drop lcd_e and lcd_db_oe immediately and abandon the request without retry.

Structure
REQ-023 Package lcd_ctrl_pkg SHALL hold the state enum and default timing constants.
REQ-024 One sub-module, lcd_delay_cnt (loadable down-counter with done flag), SHALL time all phases; the timeout counter stays inline.

Verification
REQ-025 Not-busy write: lcd_db_i=8'h00, send rs=1 data=8'h48 -> one poll E pulse of 12 cycles, then write E pulse with db_o=8'h48, rs=1, rw=0; req_ready low 32 cycles.
REQ-026 Busy twice: lcd_db_i=8'h80 for first two polls, then 8'h00, instruction 8'h01 -> three poll pulses separated by 4-cycle gaps, then one write, timeout_err=0.
REQ-027 Stuck busy: lcd_db_i=8'h80 forever, BUSY_TIMEOUT=200 -> timeout_err=1, write still issued, req_ready returns; err_clr pulse -> timeout_err=0.
REQ-028 Back-to-back: req_valid held high with 8'h38, 8'h0C, 8'h06 -> three transactions in order, no req_ready gap beyond one IDLE cycle.
REQ-029 Reset mid-write: assert RST during WR_EHIGH -> lcd_e=0, lcd_db_oe=0 same cycle; after release req_ready=1, no pending write.
REQ-030 Protocol checker throughout: RS/RW/OE stable while E=1; OE never with RW=1.
